// File: rtl/phy_gen_pkg.sv
// phy_gen_pkg: shared state encoding, mode codes, LFSR taps and next-word function for phy_gen_chk.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package phy_gen_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Generator modes
  localparam logic MODE_CNT  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // Feedback taps d7,d5,d4,d3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Next generator word. Callers truncate to their data width (up to 32 bits).
  // LFSR: the taps are taken from the word after the left shift, so 01 -> 02 -> 04 -> 09.
  function automatic logic [31:0] next_word(input logic mode, input logic [31:0] w);
    logic [31:0] s;
    if (mode == MODE_CNT) begin
      s = w + 32'd1;
    end else begin
      s    = {w[30:0], 1'b0};
      s[0] = ^(s[7:0] & LFSR_TAPS);
    end
    return s;
  endfunction

endpackage

// File: rtl/phy_gen_fifo2r.sv
// phy_gen_fifo2r: expected-word buffer, one write port and two independent in-order read ports.
// Latency: read data is combinational from the current read pointer; a write is visible the next cycle.
// Backpressure: full when either reader lags the writer by DEPTH words; caller must not write when full.
module phy_gen_fifo2r #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_4f,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         pop_a,
  input  logic         pop_b,
  output logic [W-1:0] rd_a_dat,
  output logic [W-1:0] rd_b_dat,
  output logic         empty_a,
  output logic         empty_b,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rpa;
  logic [AW:0]  rpb;

  assign empty_a  = (wp == rpa);
  assign empty_b  = (wp == rpb);
  assign full     = ((wp - rpa) == DEPTH_P) || ((wp - rpb) == DEPTH_P);
  assign rd_a_dat = mem[rpa[AW-1:0]];
  assign rd_b_dat = mem[rpb[AW-1:0]];

  // Storage array, written without reset
  always_ff @(posedge clk_4f) begin
    if (wr_vld) begin
      mem[wp[AW-1:0]] <= wr_dat;
    end
  end

  // Pointers; a write and a pop in the same cycle both take effect
  always_ff @(posedge clk_4f) begin
    if (reset || clr) begin
      wp  <= '0;
      rpa <= '0;
      rpb <= '0;
    end else begin
      if (wr_vld) wp  <= wp + (AW + 1)'(1);
      if (pop_a)  rpa <= rpa + (AW + 1)'(1);
      if (pop_b)  rpb <= rpb + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/phy_gen_chk.sv
// phy_gen_chk: stimulus generator for a DUT pair plus in-order checker of both returned streams.
// Latency: stimulus registered one cycle after the emit decision; mismatch counts update one cycle after valid_a/valid_b.
// Backpressure: generator stalls while the slower stream leaves the buffer full. Optional inject port: PHY_GEN_INJECT_EN.
module phy_gen_chk
  import phy_gen_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          SEQ_LEN    = 6,
  parameter int          REPS       = 2,
  parameter int          GAP_EVERY  = 0,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TIMEOUT    = 64,
  parameter int          CNT_W      = 8,
  parameter logic [31:0] SEED       = 32'h01
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
`ifdef PHY_GEN_INJECT_EN
  input  logic              inject,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic [DATA_W-1:0] data_a,
  input  logic              valid_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              valid_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt_a,
  output logic [CNT_W-1:0]  err_cnt_b
);
  localparam int TOTAL = SEQ_LEN * REPS;
  localparam int WC_W  = $clog2(TOTAL + 1);
  localparam int SC_W  = $clog2(SEQ_LEN + 1);
  localparam int GC_W  = $clog2(GAP_EVERY + 2);
  localparam int TC_W  = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] SEED_EFF =
    (SEED[DATA_W-1:0] == '0) ? DATA_W'(1) : SEED[DATA_W-1:0];

  logic [1:0]        state;
  logic              run_mode;
  logic [DATA_W-1:0] gen;
  logic [WC_W-1:0]   word_cnt;
  logic [SC_W-1:0]   seq_cnt;
  logic [GC_W-1:0]   gap_cnt;
  logic [TC_W-1:0]   tmo_cnt;
  logic              tmo_flag;
  logic              start_run, active, gap, emit, last_word, burst_end, flip;
  logic              empty_a, empty_b, full, pop_a, pop_b, miss_a, miss_b;
  logic [DATA_W-1:0] rd_a_dat, rd_b_dat;

  assign start_run = start && ((state == IDLE) || (state == DONE));
  assign active    = (state == RUN) || (state == DRAIN);
  assign gap       = (GAP_EVERY != 0) && (gap_cnt == GC_W'(GAP_EVERY));
  assign emit      = (state == RUN) && !gap && !full;
  assign last_word = (word_cnt == WC_W'(TOTAL - 1));
  assign burst_end = (seq_cnt == SC_W'(SEQ_LEN - 1));

  assign pop_a  = active && valid_a && !empty_a;
  assign pop_b  = active && valid_b && !empty_b;
  assign miss_a = active && valid_a && (empty_a || (data_a != rd_a_dat));
  assign miss_b = active && valid_b && (empty_b || (data_b != rd_b_dat));

  assign busy = active;
  assign done = (state == DONE);
  assign pass = done && (err_cnt_a == '0) && (err_cnt_b == '0) && !tmo_flag;

`ifdef PHY_GEN_INJECT_EN
  logic inj_pend;
  assign flip = inject || inj_pend;

  // Remember an inject pulse until the next emitted word consumes it
  always_ff @(posedge clk_4f) begin
    if (reset || start_run) begin
      inj_pend <= 1'b0;
    end else if (emit) begin
      inj_pend <= 1'b0;
    end else if (inject && (state == RUN)) begin
      inj_pend <= 1'b1;
    end
  end
`else
  assign flip = 1'b0;
`endif

  // Run control: IDLE/DONE -> RUN on start, RUN -> DRAIN after the last word, DRAIN -> DONE when drained or timed out
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state    <= IDLE;
      run_mode <= MODE_CNT;
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            run_mode <= mode;
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
          end
        end
        RUN: begin
          if (emit && last_word) state <= DRAIN;
        end
        DRAIN: begin
          if (empty_a && empty_b) begin
            state <= DONE;
          end else if (tmo_cnt == TC_W'(TIMEOUT - 1)) begin
            state    <= DONE;
            tmo_flag <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Generator: registered stimulus, reload from the seed at each burst boundary, gaps and stalls drop valid_out
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      gen       <= '0;
      word_cnt  <= '0;
      seq_cnt   <= '0;
      gap_cnt   <= '0;
    end else if (start_run) begin
      valid_out <= 1'b0;
      gen       <= SEED_EFF;
      word_cnt  <= '0;
      seq_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      valid_out <= emit;
      if (emit) begin
        data_out <= gen ^ {{(DATA_W-1){1'b0}}, flip};
        gen      <= burst_end ? SEED_EFF : DATA_W'(next_word(run_mode, 32'(gen)));
        word_cnt <= word_cnt + WC_W'(1);
        seq_cnt  <= burst_end ? '0 : seq_cnt + SC_W'(1);
        if (GAP_EVERY != 0) gap_cnt <= gap_cnt + GC_W'(1);
      end else if (gap) begin
        gap_cnt <= '0;
      end
    end
  end

  // Saturating mismatch counters; unexpected words on an empty stream also count
  always_ff @(posedge clk_4f) begin
    if (reset || start_run) begin
      err_cnt_a <= '0;
      err_cnt_b <= '0;
    end else begin
      if (miss_a && (err_cnt_a != '1)) err_cnt_a <= err_cnt_a + CNT_W'(1);
      if (miss_b && (err_cnt_b != '1)) err_cnt_b <= err_cnt_b + CNT_W'(1);
    end
  end

  // The buffer holds the true word; only data_out carries an injected flip
  phy_gen_fifo2r #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .clr      (start_run),
    .wr_vld   (emit),
    .wr_dat   (gen),
    .pop_a    (pop_a),
    .pop_b    (pop_b),
    .rd_a_dat (rd_a_dat),
    .rd_b_dat (rd_b_dat),
    .empty_a  (empty_a),
    .empty_b  (empty_b),
    .full     (full)
  );

endmodule

// File: tb/tb_phy_gen_chk.sv
// tb_phy_gen_chk: two generator/checker instances with a bench-side 2-cycle loopback per stream.
// Instance 0: counter/LFSR from seed FF, 6x2 words, no gaps. Instance 1: seed 01, 12x2 words, gap after every 2.
// Stream A can be held back, stream B can corrupt one word; emitted words are checked against a reference model.
`timescale 1ns/1ps
module tb_phy_gen_chk;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       start [2];
  logic       mode  [2];
  logic       inj   [2];
  logic [7:0] dout  [2];
  logic       vout  [2];
  logic [7:0] din_a [2];
  logic       va    [2];
  logic [7:0] din_b [2];
  logic       vb    [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic [7:0] ea    [2];
  logic [7:0] eb    [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] cap [2][64];
  int         ct  [2][64];
  int         wcnt [2], ra [2], rb [2], first_v [2], hold_until [2], bad_b [2], inj_at [2];
  bit         vh [2][128];

  always #5 clk_4f = ~clk_4f;

  phy_gen_chk #(.DATA_W(8), .SEQ_LEN(6), .REPS(2), .GAP_EVERY(0), .FIFO_DEPTH(16),
                .TIMEOUT(64), .CNT_W(8), .SEED(32'hFF)) u_a (
    .clk_4f(clk_4f), .reset(reset), .start(start[0]), .mode(mode[0]),
`ifdef PHY_GEN_INJECT_EN
    .inject(inj[0]),
`endif
    .data_out(dout[0]), .valid_out(vout[0]), .data_a(din_a[0]), .valid_a(va[0]),
    .data_b(din_b[0]), .valid_b(vb[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt_a(ea[0]), .err_cnt_b(eb[0]));

  phy_gen_chk #(.DATA_W(8), .SEQ_LEN(12), .REPS(2), .GAP_EVERY(2), .FIFO_DEPTH(16),
                .TIMEOUT(64), .CNT_W(8), .SEED(32'h01)) u_g (
    .clk_4f(clk_4f), .reset(reset), .start(start[1]), .mode(mode[1]),
`ifdef PHY_GEN_INJECT_EN
    .inject(inj[1]),
`endif
    .data_out(dout[1]), .valid_out(vout[1]), .data_a(din_a[1]), .valid_a(va[1]),
    .data_b(din_b[1]), .valid_b(vb[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt_a(ea[1]), .err_cnt_b(eb[1]));

  function automatic int seq_len(input int i);
    return (i == 0) ? 6 : 12;
  endfunction

  function automatic logic [7:0] seed_of(input int i);
    return (i == 0) ? 8'hFF : 8'h01;
  endfunction

  // Reference: each burst restarts at the seed; word k is position k mod SEQ_LEN within its burst
  function automatic logic [7:0] ref_word(input int i, input logic m, input int k);
    logic [7:0] w;
    int         pos;
    pos = k % seq_len(i);
    w   = seed_of(i);
    if (m == 1'b0) begin
      w = 8'((int'(w) + pos) % 256);
    end else begin
      for (int n = 0; n < pos; n++) begin
        w    = w << 1;
        w[0] = w[7] ^ w[5] ^ w[4] ^ w[3];
      end
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, capture emitted words, drive the loopback streams
  task automatic tick();
    @(posedge clk_4f);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (vout[i] === 1'b1 && wcnt[i] < 64) begin
        cap[i][wcnt[i]] = dout[i];
        ct[i][wcnt[i]]  = cyc;
        wcnt[i]++;
      end
      if (first_v[i] < 0 && vout[i] === 1'b1) first_v[i] = cyc;
      if (first_v[i] >= 0 && (cyc - first_v[i]) < 128) vh[i][cyc - first_v[i]] = vout[i];
      if (cyc >= hold_until[i] && ra[i] < wcnt[i] && ct[i][ra[i]] + 2 <= cyc) begin
        va[i]    = 1'b1;
        din_a[i] = cap[i][ra[i]];
        ra[i]++;
      end else begin
        va[i] = 1'b0;
      end
      if (rb[i] < wcnt[i] && ct[i][rb[i]] + 2 <= cyc) begin
        vb[i]    = 1'b1;
        din_b[i] = (rb[i] == bad_b[i]) ? 8'hAA : cap[i][rb[i]];
        rb[i]++;
      end else begin
        vb[i] = 1'b0;
      end
      inj[i] = (inj_at[i] >= 0) && (wcnt[i] == inj_at[i]) && (vout[i] === 1'b1);
    end
  endtask

  task automatic prep(input int i, input logic m, input int hold, input int badb, input int injat);
    wcnt[i] = 0; ra[i] = 0; rb[i] = 0; first_v[i] = -1;
    bad_b[i] = badb; inj_at[i] = injat; hold_until[i] = cyc + hold;
    for (int k = 0; k < 128; k++) vh[i][k] = 1'b0;
    mode[i] = m;
  endtask

  task automatic run(input int i, input logic m, input int hold, input int badb, input int injat,
                     output int dcyc, output int held_w);
    int n;
    prep(i, m, hold, badb, injat);
    held_w = -1;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    n = 0;
    while (done[i] !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (cyc == hold_until[i] - 1) held_w = wcnt[i];
    end
    dcyc = cyc;
    chk("run_done", 32'(done[i]), 32'd1);
  endtask

  task automatic chk_words(input int i, input logic m, input int injat, input int total);
    int bad;
    bad = 0;
    for (int k = 0; k < wcnt[i]; k++) begin
      if (cap[i][k] !== (ref_word(i, m, k) ^ ((k == injat) ? 8'h01 : 8'h00))) bad++;
    end
    chk("word_count", 32'(wcnt[i]), 32'(total));
    chk("word_values", 32'(bad), 32'd0);
  endtask

  initial begin
    int dcyc, held_w, bad;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; mode[i] = 1'b0; inj[i] = 1'b0; va[i] = 1'b0; vb[i] = 1'b0;
      din_a[i] = 8'h00; din_b[i] = 8'h00; wcnt[i] = 0; ra[i] = 0; rb[i] = 0;
      first_v[i] = -1; hold_until[i] = 0; bad_b[i] = -1; inj_at[i] = -1;
    end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    for (int i = 0; i < 2; i++) begin
      chk("rst_data_out", 32'(dout[i]), 32'd0);
      chk("rst_ctrl", {28'd0, vout[i], busy[i], done[i], pass[i]}, 32'd0);
      chk("rst_err", {16'd0, ea[i], eb[i]}, 32'd0);
    end

    // Counter loopback from seed FF: FF,00,01,02,03,04 per burst
    run(0, 1'b0, 0, -1, -1, dcyc, held_w);
    chk("cnt_w0", 32'(cap[0][0]), 32'hFF);
    chk("cnt_w1", 32'(cap[0][1]), 32'h00);
    chk("cnt_w5", 32'(cap[0][5]), 32'h04);
    chk("cnt_w6_restart", 32'(cap[0][6]), 32'hFF);
    chk_words(0, 1'b0, -1, 12);
    chk("cnt_pass", {30'd0, pass[0], busy[0]}, 32'h2);
    chk("cnt_err", {16'd0, ea[0], eb[0]}, 32'd0);

    // LFSR from seed 01 with a gap after every two words
    run(1, 1'b1, 0, -1, -1, dcyc, held_w);
    chk("lfsr_w0", 32'(cap[1][0]), 32'h01);
    chk("lfsr_w1", 32'(cap[1][1]), 32'h02);
    chk("lfsr_w2", 32'(cap[1][2]), 32'h04);
    chk("lfsr_w3", 32'(cap[1][3]), 32'h09);
    chk_words(1, 1'b1, -1, 24);
    bad = 0;
    for (int n = 0; n < 35; n++) if (vh[1][n] !== (n % 3 != 2)) bad++;
    chk("gap_pattern", 32'(bad), 32'd0);
    chk("lfsr_pass", 32'(pass[1]), 32'd1);

    // LFSR from seed FF, no gaps
    run(0, 1'b1, 0, -1, -1, dcyc, held_w);
    chk_words(0, 1'b1, -1, 12);
    chk("lfsr_ff_pass", 32'(pass[0]), 32'd1);

    // Stream B corrupts word 3
    run(0, 1'b0, 0, 3, -1, dcyc, held_w);
    chk("badb_err_b", 32'(eb[0]), 32'd1);
    chk("badb_err_a", 32'(ea[0]), 32'd0);
    chk("badb_pass", 32'(pass[0]), 32'd0);

    // Stream A silent: drain timeout, no mismatches but no pass
    run(0, 1'b0, 1000000, -1, -1, dcyc, held_w);
    chk("tmo_pass", 32'(pass[0]), 32'd0);
    chk("tmo_err", {16'd0, ea[0], eb[0]}, 32'd0);
    chk("tmo_latency", 32'(((dcyc - ct[0][11]) >= 63) && ((dcyc - ct[0][11]) <= 66)), 32'd1);

    // Stream A held for 80 cycles: generator stalls at 16 buffered words, then completes
    run(1, 1'b0, 80, -1, -1, dcyc, held_w);
    chk("stall_words", 32'(held_w), 32'd16);
    chk_words(1, 1'b0, -1, 24);
    chk("stall_pass", 32'(pass[1]), 32'd1);

    // Reset after 5 words, then a clean rerun
    prep(0, 1'b0, 0, -1, -1);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int n = 0; n < 50 && wcnt[0] < 5; n++) tick();
    chk("mid_words", 32'(wcnt[0]), 32'd5);
    reset = 1'b1;
    tick();
    chk("mid_rst_data", 32'(dout[0]), 32'd0);
    chk("mid_rst_ctrl", {28'd0, vout[0], busy[0], done[0], pass[0]}, 32'd0);
    chk("mid_rst_err", {16'd0, ea[0], eb[0]}, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("mid_idle", {30'd0, busy[0], done[0]}, 32'd0);
    run(0, 1'b0, 0, -1, -1, dcyc, held_w);
    chk_words(0, 1'b0, -1, 12);
    chk("rerun_pass", 32'(pass[0]), 32'd1);

`ifdef PHY_GEN_INJECT_EN
    // Inject on word 2: both streams see one mismatch
    run(0, 1'b0, 0, -1, 2, dcyc, held_w);
    chk_words(0, 1'b0, 2, 12);
    chk("inj_err_a", 32'(ea[0]), 32'd1);
    chk("inj_err_b", 32'(eb[0]), 32'd1);
    chk("inj_pass", 32'(pass[0]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
